// File: rtl/instr_stream_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_stream_encoder_pkg
// Shared definitions for the instruction stream encoder (program loader):
//   - MIPS primary opcode constants (shared with the control decoder)
//   - request kind codes carried on req_kind_i
//   - loader FSM state encoding
//   - helper that packs an I-type instruction word
// -----------------------------------------------------------------------------
package instr_stream_encoder_pkg;

  // MIPS primary opcodes
  localparam logic [5:0] R_TYPE      = 6'h00;
  localparam logic [5:0] I_TYPE_ADDI = 6'h08;
  localparam logic [5:0] I_TYPE_LUI  = 6'h0F;
  localparam logic [5:0] I_TYPE_ORI  = 6'h0D;
  localparam logic [5:0] I_TYPE_ANDI = 6'h0C;
  localparam logic [5:0] I_TYPE_LW   = 6'h23;
  localparam logic [5:0] I_TYPE_SW   = 6'h2B;
  localparam logic [5:0] I_TYPE_BEQ  = 6'h04;
  localparam logic [5:0] I_TYPE_BNE  = 6'h05;

  // Request kind codes; 9..15 are illegal
  localparam logic [3:0] KIND_R    = 4'd0;
  localparam logic [3:0] KIND_ADDI = 4'd1;
  localparam logic [3:0] KIND_LUI  = 4'd2;
  localparam logic [3:0] KIND_ORI  = 4'd3;
  localparam logic [3:0] KIND_ANDI = 4'd4;
  localparam logic [3:0] KIND_LW   = 4'd5;
  localparam logic [3:0] KIND_SW   = 4'd6;
  localparam logic [3:0] KIND_BEQ  = 4'd7;
  localparam logic [3:0] KIND_BNE  = 4'd8;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Pack an I-type word: {op, rs, rt, imm}
  function automatic logic [31:0] encode_i(input logic [5:0]  op,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_stream_encoder_field.sv
// -----------------------------------------------------------------------------
// instr_field_encoder
// Purely combinational: turns a request kind plus its fields into a 32-bit
// MIPS instruction word and flags whether the kind is legal.
// Ports:
//   kind           in  4   request kind code
//   rs/rt/rd/shamt in  5   register / shift fields
//   funct          in  6   R-type function field
//   imm            in  16  immediate / branch word offset (passed unmodified)
//   word           out 32  encoded instruction (0 for illegal kinds)
//   legal          out 1   kind is one of the supported encodings
// -----------------------------------------------------------------------------
module instr_field_encoder
  import instr_stream_encoder_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Kind-to-encoding selection
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (kind)
      KIND_R:    word = {R_TYPE, rs, rt, rd, shamt, funct};
      KIND_ADDI: word = encode_i(I_TYPE_ADDI, rs, rt, imm);
      // LUI has no source register; the rs field is forced to zero
      KIND_LUI:  word = encode_i(I_TYPE_LUI, 5'd0, rt, imm);
      KIND_ORI:  word = encode_i(I_TYPE_ORI, rs, rt, imm);
      KIND_ANDI: word = encode_i(I_TYPE_ANDI, rs, rt, imm);
      KIND_LW:   word = encode_i(I_TYPE_LW, rs, rt, imm);
      KIND_SW:   word = encode_i(I_TYPE_SW, rs, rt, imm);
      KIND_BEQ:  word = encode_i(I_TYPE_BEQ, rs, rt, imm);
      KIND_BNE:  word = encode_i(I_TYPE_BNE, rs, rt, imm);
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_stream_encoder.sv
// -----------------------------------------------------------------------------
// instr_stream_encoder
// Program loader: accepts field-level instruction requests, encodes each into
// a MIPS word and writes it to instruction memory at consecutive addresses.
// Ports:
//   clk, reset                     clock (rising edge), async active-high reset
//   start_i / finish_i             open / close a load session
//   req_valid_i / req_ready_o      request handshake
//   req_kind_i, req_rs_i, req_rt_i, req_rd_i, req_shamt_i, req_funct_i,
//   req_imm_i                      request fields
//   mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i   memory write port
//   count_o                        words written this session
//   busy_o / done_o / error_o      status
// -----------------------------------------------------------------------------
module instr_stream_encoder
  import instr_stream_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  finish_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [3:0]            req_kind_i,
  input  logic [4:0]            req_rs_i,
  input  logic [4:0]            req_rt_i,
  input  logic [4:0]            req_rd_i,
  input  logic [4:0]            req_shamt_i,
  input  logic [5:0]            req_funct_i,
  input  logic [15:0]           req_imm_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_ack_i,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  // Count value meaning every word of memory has been written
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic [ADDR_WIDTH:0]     count_r, count_s;
  logic [31:0]             wdata_r, wdata_s;
  logic                    error_r, error_s;
  logic                    pend_r, pend_s;   // finish requested while a word is in flight
  logic [31:0]             enc_word_s;
  logic                    enc_legal_s;

  instr_field_encoder u_field_encoder (
    .kind  (req_kind_i),
    .rs    (req_rs_i),
    .rt    (req_rt_i),
    .rd    (req_rd_i),
    .shamt (req_shamt_i),
    .funct (req_funct_i),
    .imm   (req_imm_i),
    .word  (enc_word_s),
    .legal (enc_legal_s)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      addr_r  <= ADDR_ZERO;
      count_r <= COUNT_ZERO;
      wdata_r <= 32'h0000_0000;
      error_r <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      count_r <= count_s;
      wdata_r <= wdata_s;
      error_r <= error_s;
      pend_r  <= pend_s;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    count_s = count_r;
    wdata_s = wdata_r;
    error_s = error_r;
    pend_s  = pend_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_s = ST_LOAD;
          addr_s  = ADDR_ZERO;
          count_s = COUNT_ZERO;
          error_s = 1'b0;
          pend_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (req_valid_i) begin
          if (enc_legal_s) begin
            wdata_s = enc_word_s;
            pend_s  = finish_i;
            state_s = ST_WRITE;
          end else begin
            // Illegal kind: nothing to write, so a simultaneous finish ends now
            error_s = 1'b1;
            state_s = finish_i ? ST_DONE : ST_LOAD;
          end
        end else if (finish_i) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (mem_ack_i) begin
          addr_s  = addr_r + ADDR_ONE;
          count_s = count_r + COUNT_ONE;
          if ((count_s == COUNT_FULL) || pend_r || finish_i) begin
            state_s = ST_DONE;
            pend_s  = 1'b0;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          pend_s = pend_r | finish_i;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers so reset clears them immediately
  assign req_ready_o = (state_r == ST_LOAD);
  assign mem_we_o    = (state_r == ST_WRITE);
  assign busy_o      = (state_r == ST_LOAD) || (state_r == ST_WRITE);
  assign done_o      = (state_r == ST_DONE);
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign count_o     = count_r;
  assign error_o     = error_r;

endmodule
